enigma_cipher_pipe: RTL and testbench
=====================================

# enigma_cipher_pipe

- Pipelined Enigma cipher core: accepts plaintext letter indices over a valid/ready handshake, steps the rotors (including the double-step), and returns ciphertext a fixed 3 cycles later.
- Path per letter: plugboard → forward rotors → reflector → inverse rotors → plugboard.
- Successor to the single-pass combinational backward path:
  - adds rotor stepping state, pipelining and backpressure;
  - adds a parameterised M4 mode (thin fourth rotor plus thin reflector).
- Sits between the keyboard/UART front end and the lampboard/output FSM.

## Interface
- `M4` (default 0): 0 = Enigma I/M3 (3 rotors, reflector B/C); 1 = M4 (adds non-stepping Greek rotor, thin reflectors).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_load` in 1: one-cycle pulse; loads start positions and flushes the pipeline.
- `rotor_sel_l`, `rotor_sel_m`, `rotor_sel_r` in 3 each: 0=I … 4=V; values 5–7 are illegal.
- `ring_l`, `ring_m`, `ring_r`, `ring_g` in 5 each: ring settings 0..25 (`ring_g` used only when M4=1).
- `start_l`, `start_m`, `start_r`, `start_g` in 5 each: positions loaded on `cfg_load`.
- `greek_sel` in 1: 0=Beta, 1=Gamma (M4=1 only).
- `refl_sel` in 1: M4=0: 0=B, 1=C; M4=1: 0=B-thin, 1=C-thin.
- `plug_map` in 130: letter i maps to bits [5i+4:5i]; must be an involution.
- `in_valid` in 1, `in_letter` in 5 (0..25): plaintext input.
- `in_ready` out 1: input accepted when high together with `in_valid`.
- `out_valid` out 1, `out_letter` out 5: ciphertext output.
- `out_ready` in 1: consumer accepts output when high.
- `pos_l`, `pos_m`, `pos_r`, `pos_g` out 5 each: current rotor positions, registered.
- Configuration inputs other than `cfg_load` and `start_*` must be held stable while any letter is in flight.

## Operation
- **Stepping** happens on each accepted letter (`in_valid && in_ready`), before encryption, using the pre-step positions:
  - Right notch by rotor: I=16(Q), II=4(E), III=21(V), IV=9(J), V=25(Z).
  - `pos_r` always increments mod 26.
  - `pos_m` increments if `pos_r` is at the right rotor's notch, or if `pos_m` is at the middle rotor's notch (double-step).
  - `pos_l` increments if `pos_m` is at the middle rotor's notch.
  - `pos_g` never steps.
  - The letter is encrypted with the post-step positions, captured into stage 0 alongside it.
- **Rotor stage**: offset = (pos − ring) mod 26, computed as (pos + 26 − ring) in 6 bits then reduced mod 26.
  - Forward: out = (wiring[(in + offset) mod 26] − offset) mod 26.
  - Inverse: same formula using the inverse wiring table.
- **Pipeline**:
  - S0 holds the letter and its positions.
  - S1 result = plugboard → R → M → L → (G if M4) forward.
  - S2 result = reflector → (G if M4) → L → M → R inverse → plugboard, registered as `out_letter`.
  - Each stage has a valid bit.
- **Stall**: `stall = out_valid && !out_ready`. While stalled, all stages hold and `in_ready = 0`. Otherwise `in_ready = 1`, so the pipeline is fully bubble-tolerant.
- **`cfg_load`**:
  - Loads `pos_*` from `start_*`.
  - Clears all stage valid bits and `out_valid`.
  - Forces `in_ready` to 0 that cycle; any `in_valid` in the same cycle is dropped without stepping.
  - Takes priority over everything except reset.
- **Illegal `rotor_sel`** (5–7): lookups return 0 and there is no notch. Output is undefined but the pipeline keeps flowing.

## Timing
- **Reset** (async assert, sync release):
  - `pos_*` = 0.
  - All valid bits 0, so `out_valid` = 0.
  - `out_letter` = 0.
  - `in_ready` = 1 in the first cycle after release.
- **Latency**: a letter accepted at edge N gives `out_valid` = 1 after edge N+3 when there is no stall.
- **Throughput**: 1 letter per cycle. Letters emerge in acceptance order.
- **Stepping timing**: `pos_*` update on the accepting edge and reflect the positions used by the letter just accepted.
- **Output hold**: `out_letter` and `out_valid` hold stable while stalled. Data is dropped only by reset or `cfg_load`.
- **Simultaneous transfer**: accept and output handshakes in the same cycle are both honoured.
- **Reset mid-stream**: all in-flight letters are discarded and positions return to 0 (not `start_*`).
- **Wrap-around**: positions roll from 25 to 0. The notch check at 25 (rotor V) triggers the neighbouring step as normal.

## Test plan
- **Basic M3 vector**: M3; rotors I-II-III, rings 0, start 0, identity plug, refl B.
  - Stimulus: 5×A (0) back-to-back.
  - Required: B D Z G O (1,3,25,6,14); positions end at 0,0,5.
  - Required: first `out_valid` 3 cycles after the first accept.
- **Double-step**: same setup, start l/m/r = 0,3,20 (ADU); 3 letters.
  - Required `pos` after each accept: ADV, AEW, BFX (0,3,21 → 0,4,22 → 1,5,23).
- **Backpressure**: 8 letters with `out_ready` toggling 1,0,0,1…
  - Required: outputs match the no-stall run in order, no drops or duplicates.
  - Required: `in_ready` = 0 exactly on stall cycles.
- **M4 thin equivalence**: M4=1; Beta at pos 0 ring 0, B-thin, I-II-III at 0.
  - Stimulus: 5×A. Required: BDZGO.
- **`cfg_load` flush**: issue `cfg_load` while 2 letters are in flight.
  - Required: no further `out_valid`; `pos_*` = `start_*`.
  - Required: a following letter encrypts from the new positions.
- **Plugboard and reset**: plug A↔B, otherwise same as the basic M3 vector.
  - Stimulus: letter A. Required: ciphertext matches the software model.
  - Stimulus: assert `rst_n` low mid-stream. Required: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/enigma_cipher_pipe.sv
// rtl/enigma_cipher_pipe.sv - pipelined Enigma I/M3/M4 cipher core with rotor stepping
// S0 letter+positions, S1 forward path, S2 backward path, then plugboarded output register.
module enigma_cipher_pipe #(
  parameter bit M4 = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic [2:0]   rotor_sel_l,
  input  logic [2:0]   rotor_sel_m,
  input  logic [2:0]   rotor_sel_r,
  input  logic [4:0]   ring_l,
  input  logic [4:0]   ring_m,
  input  logic [4:0]   ring_r,
  input  logic [4:0]   ring_g,
  input  logic [4:0]   start_l,
  input  logic [4:0]   start_m,
  input  logic [4:0]   start_r,
  input  logic [4:0]   start_g,
  input  logic         greek_sel,
  input  logic         refl_sel,
  input  logic [129:0] plug_map,
  input  logic         in_valid,
  input  logic [4:0]   in_letter,
  output logic         in_ready,
  output logic         out_valid,
  output logic [4:0]   out_letter,
  input  logic         out_ready,
  output logic [4:0]   pos_l,
  output logic [4:0]   pos_m,
  output logic [4:0]   pos_r,
  output logic [4:0]   pos_g
);

  localparam logic [207:0] W_I      = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] W_II     = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] W_III    = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [207:0] W_IV     = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [207:0] W_V      = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [207:0] W_BETA   = "LEYJVCNIXWPBQMDRTAKZGFUHOS";
  localparam logic [207:0] W_GAMMA  = "FSOKANUERHMBTIYCWLQPZXVGJD";
  localparam logic [207:0] R_B      = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [207:0] R_C      = "FVPJIAOYEDRZXWGCTKUQSBNMHL";
  localparam logic [207:0] R_B_THIN = "ENKQAUYWJICOPBLMDXZVFTHRGS";
  localparam logic [207:0] R_C_THIN = "RDOBJNTKVEHMLFCWZAXGYIPSUQ";

  // Tables are ASCII strings; letter 0 sits in the most significant byte.
  function automatic logic [4:0] tab(input logic [207:0] t, input logic [4:0] i);
    logic [7:0] sh;
    logic [7:0] c;
    if (i > 5'd25) return 5'd0;
    sh = {3'd0, 5'd25 - i} << 3;
    c  = t[sh +: 8] - 8'd65;
    return c[4:0];
  endfunction

  function automatic logic [4:0] mod26(input logic [5:0] v);
    return (v >= 6'd26) ? 5'(v - 6'd26) : v[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  // Codes 0..4 are rotors I..V, 8/9 are Beta/Gamma; anything else reads as 0.
  function automatic logic [4:0] wiring(input logic [3:0] code, input logic [4:0] i);
    case (code)
      4'd0:    return tab(W_I, i);
      4'd1:    return tab(W_II, i);
      4'd2:    return tab(W_III, i);
      4'd3:    return tab(W_IV, i);
      4'd4:    return tab(W_V, i);
      4'd8:    return tab(W_BETA, i);
      4'd9:    return tab(W_GAMMA, i);
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] wiring_inv(input logic [3:0] code, input logic [4:0] x);
    logic [4:0] r;
    r = 5'd0;
    if (code <= 4'd4 || code == 4'd8 || code == 4'd9)
      for (int j = 0; j < 26; j++)
        if (wiring(code, 5'(j)) == x) r = 5'(j);
    return r;
  endfunction

  function automatic logic [4:0] rotor(input logic [3:0] code, input logic [4:0] pos,
                                       input logic [4:0] ring, input logic [4:0] in, input logic inv);
    logic [4:0] off;
    logic [4:0] idx;
    logic [4:0] w;
    off = mod26({1'b0, pos} + 6'd26 - {1'b0, ring});
    idx = mod26({1'b0, in} + {1'b0, off});
    w   = inv ? wiring_inv(code, idx) : wiring(code, idx);
    return mod26({1'b0, w} + 6'd26 - {1'b0, off});
  endfunction

  function automatic logic [4:0] reflect(input logic sel, input logic [4:0] i);
    if (M4) return sel ? tab(R_C_THIN, i) : tab(R_B_THIN, i);
    return sel ? tab(R_C, i) : tab(R_B, i);
  endfunction

  function automatic logic [4:0] plug(input logic [129:0] map, input logic [4:0] i);
    logic [7:0] b;
    if (i > 5'd25) return 5'd0;
    b = {3'd0, i} * 8'd5;
    return map[b +: 5];
  endfunction

  function automatic logic at_notch(input logic [2:0] sel, input logic [4:0] pos);
    case (sel)
      3'd0:    return pos == 5'd16;
      3'd1:    return pos == 5'd4;
      3'd2:    return pos == 5'd21;
      3'd3:    return pos == 5'd9;
      3'd4:    return pos == 5'd25;
      default: return 1'b0;
    endcase
  endfunction

  logic       s0_v, s1_v, s2_v;
  logic [4:0] s0_letter, s1_letter, s2_letter;
  logic [4:0] s0_l, s0_m, s0_r, s0_g, s1_l, s1_m, s1_r, s1_g;
  logic [4:0] nxt_l, nxt_m, nxt_r, fwd, bwd;
  logic       stall, accept, mid_turn, r_turn;
  logic [3:0] code_l, code_m, code_r, code_g;

  assign code_l   = {1'b0, rotor_sel_l};
  assign code_m   = {1'b0, rotor_sel_m};
  assign code_r   = {1'b0, rotor_sel_r};
  assign code_g   = greek_sel ? 4'd9 : 4'd8;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !cfg_load;
  assign accept   = in_valid && in_ready;

  // Middle rotor at its own notch turns itself and the left rotor: the double-step.
  assign mid_turn = at_notch(rotor_sel_m, pos_m);
  assign r_turn   = at_notch(rotor_sel_r, pos_r);
  assign nxt_r    = inc26(pos_r);
  assign nxt_m    = (r_turn || mid_turn) ? inc26(pos_m) : pos_m;
  assign nxt_l    = mid_turn ? inc26(pos_l) : pos_l;

  always_comb begin
    fwd = plug(plug_map, s0_letter);
    fwd = rotor(code_r, s0_r, ring_r, fwd, 1'b0);
    fwd = rotor(code_m, s0_m, ring_m, fwd, 1'b0);
    fwd = rotor(code_l, s0_l, ring_l, fwd, 1'b0);
    if (M4) fwd = rotor(code_g, s0_g, ring_g, fwd, 1'b0);
  end

  always_comb begin
    bwd = reflect(refl_sel, s1_letter);
    if (M4) bwd = rotor(code_g, s1_g, ring_g, bwd, 1'b1);
    bwd = rotor(code_l, s1_l, ring_l, bwd, 1'b1);
    bwd = rotor(code_m, s1_m, ring_m, bwd, 1'b1);
    bwd = rotor(code_r, s1_r, ring_r, bwd, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_l <= '0; pos_m <= '0; pos_r <= '0; pos_g <= '0;
      s0_v <= 1'b0; s1_v <= 1'b0; s2_v <= 1'b0; out_valid <= 1'b0;
      s0_letter <= '0; s1_letter <= '0; s2_letter <= '0; out_letter <= '0;
      s0_l <= '0; s0_m <= '0; s0_r <= '0; s0_g <= '0;
      s1_l <= '0; s1_m <= '0; s1_r <= '0; s1_g <= '0;
    end else if (cfg_load) begin
      pos_l <= start_l; pos_m <= start_m; pos_r <= start_r; pos_g <= start_g;
      s0_v <= 1'b0; s1_v <= 1'b0; s2_v <= 1'b0; out_valid <= 1'b0;
    end else begin
      if (accept) begin
        pos_l <= nxt_l; pos_m <= nxt_m; pos_r <= nxt_r;
      end
      if (!stall) begin
        s0_v <= accept;
        if (accept) begin
          s0_letter <= in_letter;
          s0_l <= nxt_l; s0_m <= nxt_m; s0_r <= nxt_r; s0_g <= pos_g;
        end
        s1_v <= s0_v; s1_letter <= fwd;
        s1_l <= s0_l; s1_m <= s0_m; s1_r <= s0_r; s1_g <= s0_g;
        s2_v <= s1_v; s2_letter <= bwd;
        out_valid  <= s2_v;
        out_letter <= plug(plug_map, s2_letter);
      end
    end
  end

endmodule

// File: tb/tb_enigma_cipher_pipe.sv
// tb/tb_enigma_cipher_pipe.sv - directed scoreboard bench for enigma_cipher_pipe (M3 and M4 instances)
module tb_enigma_cipher_pipe;

  logic         clk, rst_n, cfg_load;
  logic [2:0]   rotor_sel_l, rotor_sel_m, rotor_sel_r;
  logic [4:0]   ring_l, ring_m, ring_r, ring_g;
  logic [4:0]   start_l, start_m, start_r, start_g;
  logic         greek_sel, refl_sel;
  logic [129:0] plug_map;
  logic         in_valid, out_ready;
  logic [4:0]   in_letter;
  logic         in_ready, out_valid, in_ready4, out_valid4;
  logic [4:0]   out_letter, pos_l, pos_m, pos_r, pos_g;
  logic [4:0]   out_letter4, pos_l4, pos_m4, pos_r4, pos_g4;

  enigma_cipher_pipe #(.M4(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .rotor_sel_l(rotor_sel_l), .rotor_sel_m(rotor_sel_m), .rotor_sel_r(rotor_sel_r),
    .ring_l(ring_l), .ring_m(ring_m), .ring_r(ring_r), .ring_g(ring_g),
    .start_l(start_l), .start_m(start_m), .start_r(start_r), .start_g(start_g),
    .greek_sel(greek_sel), .refl_sel(refl_sel), .plug_map(plug_map),
    .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .pos_g(pos_g));

  enigma_cipher_pipe #(.M4(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .rotor_sel_l(rotor_sel_l), .rotor_sel_m(rotor_sel_m), .rotor_sel_r(rotor_sel_r),
    .ring_l(ring_l), .ring_m(ring_m), .ring_r(ring_r), .ring_g(ring_g),
    .start_l(start_l), .start_m(start_m), .start_r(start_r), .start_g(start_g),
    .greek_sel(greek_sel), .refl_sel(refl_sel), .plug_map(plug_map),
    .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_letter(out_letter4), .out_ready(out_ready),
    .pos_l(pos_l4), .pos_m(pos_m4), .pos_r(pos_r4), .pos_g(pos_g4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  string ROT [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                     "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                     "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string REFL [2] = '{"YRUHQSLDPXNGOKMIEBFZCWVJAT", "FVPJIAOYEDRZXWGCTKUQSBNMHL"};

  int checks = 0, failures = 0;
  int ml, mm, mr, mg;
  int plug_tab [26];
  int exq [$];
  int got [$];
  bit ev [4];
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build_plug();
    for (int i = 0; i < 26; i++) plug_map[5*i +: 5] = 5'(plug_tab[i]);
  endtask

  function automatic int mrot(input int w, input int pos, input int ring, input int c, input bit inv);
    int off, x, y;
    string s;
    s = ROT[w];
    off = (pos - ring + 26) % 26;
    x = (c + off) % 26;
    y = 0;
    if (!inv) y = int'(s.getc(x)) - 65;
    else for (int j = 0; j < 26; j++) if (int'(s.getc(j)) - 65 == x) y = j;
    return (y - off + 26) % 26;
  endfunction

  function automatic int mencrypt(input int c0);
    int c;
    string s;
    c = plug_tab[c0];
    c = mrot(int'(rotor_sel_r), mr, int'(ring_r), c, 1'b0);
    c = mrot(int'(rotor_sel_m), mm, int'(ring_m), c, 1'b0);
    c = mrot(int'(rotor_sel_l), ml, int'(ring_l), c, 1'b0);
    s = REFL[refl_sel];
    c = int'(s.getc(c)) - 65;
    c = mrot(int'(rotor_sel_l), ml, int'(ring_l), c, 1'b1);
    c = mrot(int'(rotor_sel_m), mm, int'(ring_m), c, 1'b1);
    c = mrot(int'(rotor_sel_r), mr, int'(ring_r), c, 1'b1);
    return plug_tab[c];
  endfunction

  task automatic mstep();
    int nr [5] = '{16, 4, 21, 9, 25};
    bit mt, rt;
    mt = (mm == nr[rotor_sel_m]);
    rt = (mr == nr[rotor_sel_r]);
    if (rt || mt) mm = (mm + 1) % 26;
    if (mt) ml = (ml + 1) % 26;
    mr = (mr + 1) % 26;
  endtask

  // Called just after a falling edge with inputs already driven; returns one falling edge later.
  task automatic step();
    bit stall_e, acc_e, xfer_e;
    int e;
    #1;
    stall_e = ev[3] && !out_ready;
    acc_e   = in_valid && !stall_e && !cfg_load;
    xfer_e  = ev[3] && out_ready;
    chk("in_ready", in_ready, !stall_e && !cfg_load);
    chk("out_valid", out_valid, ev[3]);
    chk("out_valid_m4", out_valid4, ev[3]);
    if (xfer_e && exq.size() != 0) begin
      e = exq.pop_front();
      chk("out_letter", out_letter, e);
      chk("out_letter_m4", out_letter4, e);
      got.push_back(int'(out_letter));
    end
    if (acc_e) begin
      mstep();
      exq.push_back(mencrypt(int'(in_letter)));
    end
    if (cfg_load) begin
      ml = start_l; mm = start_m; mr = start_r; mg = start_g;
      exq.delete();
    end
    last_acc = acc_e;
    @(posedge clk);
    if (cfg_load) ev = '{0, 0, 0, 0};
    else if (!stall_e) begin
      ev[3] = ev[2]; ev[2] = ev[1]; ev[1] = ev[0]; ev[0] = acc_e;
    end
    #1;
    chk("pos_l", pos_l, ml);
    chk("pos_m", pos_m, mm);
    chk("pos_r", pos_r, mr);
    chk("pos_r_m4", pos_r4, mr);
    chk("pos_g_m4", pos_g4, mg);
    @(negedge clk);
  endtask

  task automatic cfg(input int l, input int m, input int r);
    start_l = 5'(l); start_m = 5'(m); start_r = 5'(r);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    int bdzgo [5] = '{1, 3, 25, 6, 14};
    int ds [3][3] = '{'{0, 3, 21}, '{0, 4, 22}, '{1, 5, 23}};
    int wr [3][3] = '{'{2, 7, 25}, '{2, 8, 0}, '{2, 8, 1}};
    int sent, cyc;

    rst_n = 1'b0; cfg_load = 1'b0;
    rotor_sel_l = 3'd0; rotor_sel_m = 3'd1; rotor_sel_r = 3'd2;
    ring_l = 0; ring_m = 0; ring_r = 0; ring_g = 0;
    start_l = 0; start_m = 0; start_r = 0; start_g = 0;
    greek_sel = 1'b0; refl_sel = 1'b0;
    in_valid = 1'b0; in_letter = 0; out_ready = 1'b1;
    for (int i = 0; i < 26; i++) plug_tab[i] = i;
    build_plug();
    ml = 0; mm = 0; mr = 0; mg = 0;
    ev = '{0, 0, 0, 0};

    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_letter", out_letter, 0);
    chk("rst_pos", {pos_l, pos_m, pos_r, pos_g}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic M3 vector, M4 instance checked for thin equivalence alongside
    got.delete();
    in_valid = 1'b1; in_letter = 0;
    repeat (5) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bdzgo_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bdzgo", got[i], bdzgo[i]);
    chk("basic_end_pos", {pos_l, pos_m, pos_r}, {5'd0, 5'd0, 5'd5});

    // Double-step from ADU
    cfg(0, 3, 20);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_letter = 5'(i);
      step();
      chk("double_step_pos", {pos_l, pos_m, pos_r}, {5'(ds[i][0]), 5'(ds[i][1]), 5'(ds[i][2])});
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure with reflector C / Gamma
    refl_sel = 1'b1; greek_sel = 1'b1;
    cfg(0, 0, 0);
    got.delete();
    sent = 0; cyc = 0;
    while ((sent < 8 || ev[0] || ev[1] || ev[2] || ev[3]) && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      in_letter = 5'((sent * 7 + 3) % 26);
      step();
      if (last_acc) sent++;
      cyc++;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    chk("bp_sent", sent, 8);
    chk("bp_received", got.size(), 8);
    chk("bp_drained", exq.size(), 0);
    refl_sel = 1'b0; greek_sel = 1'b0;

    // cfg_load flush with two letters in flight, then rotor V wrap at Z
    cfg(0, 0, 0);
    in_valid = 1'b1;
    in_letter = 4; step();
    in_letter = 9; step();
    rotor_sel_r = 3'd4;
    cfg(2, 7, 24);
    in_valid = 1'b0;
    repeat (5) step();
    chk("flush_pos", {pos_l, pos_m, pos_r}, {5'd2, 5'd7, 5'd24});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_letter = 5'(i + 10);
      step();
      chk("wrap_pos", {pos_l, pos_m, pos_r}, {5'(wr[i][0]), 5'(wr[i][1]), 5'(wr[i][2])});
    end
    in_valid = 1'b0;
    repeat (5) step();

    // Plugboard A<->B
    rotor_sel_r = 3'd2;
    plug_tab[0] = 1; plug_tab[1] = 0;
    build_plug();
    cfg(0, 0, 0);
    in_valid = 1'b1; in_letter = 0;
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // Reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_letter = 5'(i + 20);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_valid_m4", out_valid4, 0);
    chk("midrst_out_letter", out_letter, 0);
    chk("midrst_pos", {pos_l, pos_m, pos_r, pos_g}, 0);
    ml = 0; mm = 0; mr = 0; mg = 0;
    exq.delete();
    ev = '{0, 0, 0, 0};
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_letter = 7;
    step();
    in_valid = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
